// File: rtl/scan_decoder_pkg.sv
// Shared types and the one-hot decode helper for the scan decoder family.
package scan_decoder_pkg;

   typedef enum logic [1:0] {IDLE, DIRECT, DRIVE, BLANK} scan_state_t;

   // Widest select the helper supports; callers cast the result down to their own width.
   localparam int unsigned MAX_SEL_W = 8;
   localparam int unsigned MAX_OUT   = 2 ** MAX_SEL_W;

   function automatic logic [MAX_OUT-1:0] onehot_dec(input logic [MAX_SEL_W-1:0] sel);
      onehot_dec = MAX_OUT'(1) << sel;
   endfunction

endpackage

// File: rtl/scan_decoder_if.sv
// Control/strobe bundle between a scan_decoder and whoever drives it.
interface scan_decoder_if #(
   parameter int SEL_W = 4
);
   localparam int unsigned NUM_OUT = 2 ** SEL_W;

   logic               en;
   logic               mode;
   logic [SEL_W-1:0]   sel;
   logic [NUM_OUT-1:0] op;
   logic [SEL_W-1:0]   idx;
   logic               frame_done;
   logic               busy;

   modport master (output en, mode, sel, input op, idx, frame_done, busy);
   modport slave  (input en, mode, sel, output op, idx, frame_done, busy);
endinterface

// File: rtl/scan_decoder_onehot.sv
// Parametrised combinational n-to-2**n decoder with enable.
module onehot_decoder
   import scan_decoder_pkg::*;
#(
   parameter int SEL_W = 4
) (
   input  logic                    en,
   input  logic [SEL_W-1:0]        a,
   output logic [(2**SEL_W)-1:0]   op
);
   localparam int unsigned NUM_OUT = 2 ** SEL_W;

   if (SEL_W < 1 || SEL_W > MAX_SEL_W) begin : g_chk_sel_w
      $error("onehot_decoder: SEL_W out of supported range");
   end

   assign op = en ? NUM_OUT'(onehot_dec(MAX_SEL_W'(a))) : '0;

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot line driver: direct decode of sel, or autonomous
// round-robin scan with dwell and blanking gap.
module scan_decoder
   import scan_decoder_pkg::*;
#(
   parameter int SEL_W    = 4,
   parameter int LAST_IDX = 15,
   parameter int DWELL    = 4,
   parameter int BLANK    = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   scan_decoder_if.slave  bus
);
   localparam int unsigned NUM_OUT   = 2 ** SEL_W;
   localparam int unsigned CNT_MAX   = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
   localparam int unsigned DWELL_END = (DWELL > 0) ? DWELL - 1 : 0;
   localparam int unsigned BLANK_END = (BLANK > 0) ? BLANK - 1 : 0;
   localparam logic [SEL_W-1:0] LAST = SEL_W'(LAST_IDX);

   if (DWELL < 1) begin : g_chk_dwell
      $error("scan_decoder: DWELL must be >= 1");
   end
   if (BLANK < 0) begin : g_chk_blank
      $error("scan_decoder: BLANK must be >= 0");
   end
   if (LAST_IDX < 0 || LAST_IDX >= (2 ** SEL_W)) begin : g_chk_last
      $error("scan_decoder: LAST_IDX must lie in 0..NUM_OUT-1");
   end

   scan_state_t        state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SEL_W-1:0]   idx_q, idx_d, idx_nxt;
   logic               fd_q, fd_d;
   logic               busy_q;
   logic [NUM_OUT-1:0] op_q, dec_op;
   logic               dec_en;
   logic               wrap;

   assign wrap    = (idx_q == LAST);
   assign idx_nxt = wrap ? '0 : idx_q + SEL_W'(1);

   // The decoder sees the line the next state will show, so op lands with its state.
   onehot_decoder #(.SEL_W(SEL_W)) u_dec (
      .en (dec_en),
      .a  (idx_d),
      .op (dec_op)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         fd_q    <= 1'b0;
         busy_q  <= 1'b0;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         fd_q    <= fd_d;
         busy_q  <= (state_d != IDLE);
         op_q    <= dec_op;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      fd_d    = 1'b0;
      dec_en  = 1'b0;
      if (!bus.en) begin
         state_d = IDLE;
         cnt_d   = '0;
         idx_d   = '0;
      end else if (!bus.mode) begin
         state_d = DIRECT;
         cnt_d   = '0;
         idx_d   = bus.sel;
         dec_en  = 1'b1;
      end else begin
         unique case (state_q)
            IDLE, DIRECT: begin
               state_d = DRIVE;
               cnt_d   = '0;
               idx_d   = '0;
               dec_en  = 1'b1;
            end
            DRIVE: begin
               if (cnt_q == CNT_W'(DWELL_END)) begin
                  cnt_d = '0;
                  if (BLANK > 0) begin
                     state_d = scan_decoder_pkg::BLANK;
                  end else begin
                     idx_d  = idx_nxt;
                     fd_d   = wrap;
                     dec_en = 1'b1;
                  end
               end else begin
                  cnt_d  = cnt_q + CNT_W'(1);
                  dec_en = 1'b1;
               end
            end
            scan_decoder_pkg::BLANK: begin
               if (cnt_q == CNT_W'(BLANK_END)) begin
                  state_d = DRIVE;
                  cnt_d   = '0;
                  idx_d   = idx_nxt;
                  fd_d    = wrap;
                  dec_en  = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign bus.op         = op_q;
   assign bus.idx        = idx_q;
   assign bus.frame_done = fd_q;
   assign bus.busy       = busy_q;

endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
- Parametrised, registered successor to the fixed 4-to-16 enable-cascade decoder.
- Produces a one-hot output vector of 2**SEL_W lines in one of two modes:
  - direct: registered decode of a select input;
  - scan: autonomous round-robin over lines 0..LAST_IDX, with a programmable dwell time and blanking gap.
- Drives row/digit strobes for multiplexed displays and keypads, and chip-selects in time-sliced peripherals.

Parameters:
- SEL_W, 4, select width; output width NUM_OUT = 2**SEL_W.
- LAST_IDX, 15, highest index visited in scan mode; legal range 0..NUM_OUT-1.
- DWELL, 4, cycles each line is held high in scan mode; must be >= 1.
- BLANK, 1, all-zero cycles between consecutive lines in scan mode; must be >= 0.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; synchronous, active-low.
- en  in  1  global enable; low forces outputs idle.
- mode  in  1  0 = direct decode, 1 = scan.
- sel  in  SEL_W  line to assert in direct mode; ignored in scan mode.
- op  out  NUM_OUT  registered one-hot (or all-zero) output.
- idx  out  SEL_W  index of the currently selected line.
- frame_done  out  1  one-cycle pulse each time the scan wraps to line 0.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst_n sampled low at a clk edge):
  - state=IDLE; op=0, idx=0, frame_done=0, busy=0; dwell/blank counter=0.
  - Reset has priority over all other inputs. Reset mid-scan aborts immediately; there is no partial dwell afterwards.
- States: IDLE, DIRECT, DRIVE, BLANK. All outputs are registered and there is no combinational path from input to output.
- IDLE:
  - op=0.
  - en=1, mode=0 -> DIRECT.
  - en=1, mode=1 -> DRIVE with idx=0.
- DIRECT:
  - Each cycle: op <= 1<<sel, idx <= sel. Latency is 1 cycle from sel to op.
  - The full 0..NUM_OUT-1 range is decoded; LAST_IDX does not apply.
  - mode=1 -> DRIVE at idx=0 (scan restarts, no frame_done).
- DRIVE:
  - op = 1<<idx for exactly DWELL consecutive cycles. The counter counts 0..DWELL-1.
  - At the end of dwell with BLANK>0 -> BLANK, idx unchanged.
  - At the end of dwell with BLANK=0 -> DRIVE at the next idx, back-to-back with no gap.
- BLANK:
  - op=0 for exactly BLANK cycles, then DRIVE at the next idx.
- Next-idx rule: idx+1, or 0 when idx==LAST_IDX.
- frame_done:
  - High for exactly the first cycle of DRIVE at idx=0 reached by wrap from LAST_IDX.
  - Never asserted on initial entry from IDLE/DIRECT.
- Scan period is (LAST_IDX+1)*(DWELL+BLANK) cycles.
- LAST_IDX=0: line 0 is re-driven every period; frame_done pulses every DWELL+BLANK cycles.
- en low in any state -> IDLE on the next edge; op=0, idx=0, frame_done=0.
- mode 1->0 mid-scan -> DIRECT on the next edge; op=1<<sel is visible that same edge.
- At most one bit of op is ever high. No cycle shows two lines asserted, including on mode changes.
- Counter width is $clog2(max(DWELL,BLANK)+1). Counter arithmetic is unsigned, with no overflow in legal configurations.
- Elaboration-time assertions: DWELL>=1, BLANK>=0, LAST_IDX<NUM_OUT.

Decomposition:
- Package scan_decoder_pkg holds:
  - typedef enum logic [1:0] scan_state_t {IDLE, DIRECT, DRIVE, BLANK};
  - function onehot_dec(sel) returning 1<<sel, parametrised by width.
- One combinational sub-module, onehot_decoder #(SEL_W), is the natural split. It has inputs en and a, and output op.
  - It generalises the 2-to-4/4-to-16 cascade into a single parametrised block.
  - It is shared with future direct-only users.
  - scan_decoder instantiates it and registers its output.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with en=1, mode=1 -> op=0, idx=0, busy=0, frame_done=0 throughout; scanning begins 1 cycle after rst_n rises.
- Direct mode (defaults): en=1, mode=0, sel=5 then sel=15 -> op=16'h0020 then 16'h8000, each 1 cycle after sel; idx follows; frame_done never set.
- Scan: DWELL=3, BLANK=1, LAST_IDX=3 -> op sequence 0001×3, 0000, 0002×3, 0000, 0004×3, 0000, 0008×3, 0000, then 0001.
  - frame_done pulses on the second 0001 entry only.
  - Period is 16 cycles.
- BLANK=0, DWELL=2, LAST_IDX=2 -> 001,001,010,010,100,100,001,...; never all-zero between lines; frame_done every 6 cycles.
- Disruption mid-scan, each applied at idx=2 mid-dwell:
  - en dropped -> op=0, idx=0 next edge; re-enable restarts at line 0 with no frame_done.
  - rst_n pulsed -> same result.
  - mode->0 with sel=9 -> op=16'h0200 next edge.
- Random en/mode/sel for 10k cycles with an assertion monitor -> $onehot0(op) always; op asserted only in DIRECT/DRIVE.
